// File: rtl/ram_arb_pkg.sv
// Shared types for the two-requester RAM arbiter.
// Optional feature macro used by this slice: RAM_ARB_ROUND_ROBIN_EN.
package ram_arb_pkg;

    localparam int unsigned N_REQ = 2;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RDATA
    } state_t;

    function automatic logic [N_REQ-1:0] req_onehot(input logic idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/ram_arb_if.sv
// Requester-side and RAM-side bus of the arbiter; master drives requests and RAM read data.
// Optional feature macro used by this slice: RAM_ARB_ROUND_ROBIN_EN (no effect here).
interface ram_arb_if #(
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned DATA_W = 1
);
    import ram_arb_pkg::*;

    logic [N_REQ-1:0]  req;
    logic [N_REQ-1:0]  we;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [N_REQ-1:0]  gnt;
    logic [N_REQ-1:0]  rvalid;
    logic [DATA_W-1:0] rdata;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output req, we, addr0, addr1, wdata0, wdata1, ram_rdata,
        input  gnt, rvalid, rdata, ram_en, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1, ram_rdata,
        output gnt, rvalid, rdata, ram_en, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/ram_arb_pick.sv
// Combinational winner select between the two requesters.
// RAM_ARB_ROUND_ROBIN_EN: tie goes to the requester that is not ptr; otherwise requester 0 wins.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic             ptr,
    output logic             win
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
    always_comb begin
        win = ~req[0] & req[1];
        if (req == 2'b11) begin
            win = ~ptr;
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ptr;

    always_comb begin
        win = ~req[0] & req[1];
    end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter for a single-port RAM with 1-cycle read latency.
// RAM_ARB_ROUND_ROBIN_EN: round-robin tie break with a last-winner pointer; default is fixed priority.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned DATA_W = 1
) (
    input  logic     clock,
    input  logic     reset,
    ram_arb_if.slave bus
);

    state_t            state;
    logic              win;
    logic              ptr;
    logic              win_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [N_REQ-1:0]  gnt_q;
    logic [N_REQ-1:0]  rvalid_q;
    logic              ram_en_q;
    logic              ram_we_q;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic last_q;
    assign ptr = last_q;
`else
    assign ptr = 1'b0;
`endif

    ram_arb_pick u_pick (
        .req (bus.req),
        .ptr (ptr),
        .win (win)
    );

    // Strobes are registered on entry to ACCESS/RDATA so they line up with the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            win_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            ram_en_q <= 1'b0;
            ram_we_q <= 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_q   <= 1'b1;
`endif
        end else begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            ram_en_q <= 1'b0;
            ram_we_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        win_q    <= win;
                        we_q     <= bus.we[win];
                        addr_q   <= win ? bus.addr1 : bus.addr0;
                        wdata_q  <= win ? bus.wdata1 : bus.wdata0;
                        gnt_q    <= req_onehot(win);
                        ram_en_q <= 1'b1;
                        ram_we_q <= bus.we[win];
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
                    last_q <= win_q;
`endif
                    if (we_q) begin
                        state <= IDLE;
                    end else begin
                        rvalid_q <= req_onehot(win_q);
                        state    <= RDATA;
                    end
                end
                RDATA: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.rdata     = (state == RDATA) ? bus.ram_rdata : '0;
    assign bus.ram_en    = ram_en_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: transaction-level model predicts grant order, timing and read data.
// Builds for either setting of RAM_ARB_ROUND_ROBIN_EN.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    localparam int unsigned AW    = 2;
    localparam int unsigned DW    = 1;
    localparam int unsigned DEPTH = 1 << AW;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ram_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int            idx;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            gcyc;
    } exp_t;

    exp_t          expq[$];
    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    bit            mon_en   = 1'b0;
    bit            load_en  = 1'b1;
    logic [DW-1:0] ram       [DEPTH];
    logic [DW-1:0] model_mem [DEPTH];
    int            last_win  = 1;

    always @(posedge clock) cyc <= cyc + 1;

    // Environment RAM: one-cycle read latency, preloaded from the model image during reset.
    always @(posedge clock) begin
        if (load_en) begin
            for (int i = 0; i < int'(DEPTH); i++) ram[i] <= model_mem[i];
        end else if (bus.ram_en) begin
            if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
            bus.ram_rdata <= ram[bus.ram_addr];
        end
    end

    task automatic check(input string name, input longint act, input longint req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, req_v, cyc);
        end
    endtask

    function automatic int tie_winner();
`ifdef RAM_ARB_ROUND_ROBIN_EN
        return 1 - last_win;
`else
        return 0;
`endif
    endfunction

    function automatic void expect_access(input int idx, input logic we, input logic [AW-1:0] addr,
                                          input logic [DW-1:0] wdata, input int gcyc);
        exp_t e;
        e.idx   = idx;
        e.we    = we;
        e.addr  = addr;
        e.wdata = wdata;
        e.gcyc  = gcyc;
        e.rdata = '0;
        if (we) model_mem[addr] = wdata;
        else    e.rdata = model_mem[addr];
        last_win = idx;
        expq.push_back(e);
    endfunction

    // Monitor: every negedge, pop on a grant and check the expected rvalid slot.
    exp_t          mon_e;
    bit            rd_pend = 1'b0;
    int            rd_idx;
    int            rd_cyc;
    logic [DW-1:0] rd_data;

    always @(negedge clock) begin
        if (mon_en) begin
            if (rd_pend && cyc == rd_cyc) begin
                check("rvalid", bus.rvalid, 1 << rd_idx);
                check("rdata", bus.rdata, rd_data);
                rd_pend = 1'b0;
            end else begin
                check("rvalid_idle", bus.rvalid, 0);
                check("rdata_idle", bus.rdata, 0);
            end
            if (bus.gnt != '0) begin
                if (expq.size() == 0) begin
                    check("unexpected_gnt", bus.gnt, 0);
                end else begin
                    mon_e = expq.pop_front();
                    check("gnt", bus.gnt, 1 << mon_e.idx);
                    check("gnt_cycle", cyc, mon_e.gcyc);
                    check("ram_en", bus.ram_en, 1);
                    check("ram_we", bus.ram_we, mon_e.we);
                    check("ram_addr", bus.ram_addr, mon_e.addr);
                    if (mon_e.we) begin
                        check("ram_wdata", bus.ram_wdata, mon_e.wdata);
                    end else begin
                        rd_pend = 1'b1;
                        rd_idx  = mon_e.idx;
                        rd_data = mon_e.rdata;
                        rd_cyc  = cyc + 1;
                    end
                end
            end else begin
                check("ram_en_idle", bus.ram_en, 0);
                check("ram_we_idle", bus.ram_we, 0);
            end
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, bus.gnt, 0);
        check({tag, "_rvalid"}, bus.rvalid, 0);
        check({tag, "_rdata"}, bus.rdata, 0);
        check({tag, "_ram_en"}, bus.ram_en, 0);
        check({tag, "_ram_we"}, bus.ram_we, 0);
        check({tag, "_ram_addr"}, bus.ram_addr, 0);
        check({tag, "_ram_wdata"}, bus.ram_wdata, 0);
    endtask

    // One round: requesters in pat each issue one access and drop req on their own grant.
    task automatic run_round(input logic [1:0] pat, input logic [1:0] wev,
                             input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                             input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        int first;
        int second;
        int g;
        int budget;
        bus.we     = wev;
        bus.addr0  = a0;
        bus.addr1  = a1;
        bus.wdata0 = d0;
        bus.wdata1 = d1;
        g = cyc + 1;
        if (pat == 2'b11) begin
            first  = tie_winner();
            second = 1 - first;
            expect_access(first, wev[first], (first != 0) ? a1 : a0, (first != 0) ? d1 : d0, g);
            g += wev[first] ? 2 : 3;
            expect_access(second, wev[second], (second != 0) ? a1 : a0, (second != 0) ? d1 : d0, g);
        end else begin
            first = pat[0] ? 0 : 1;
            expect_access(first, wev[first], (first != 0) ? a1 : a0, (first != 0) ? d1 : d0, g);
        end
        bus.req = pat;
        budget  = 0;
        while (bus.req != '0 && budget < 12) begin
            tick();
            budget++;
            for (int i = 0; i < 2; i++) begin
                if (bus.gnt[i]) bus.req[i] = 1'b0;
            end
        end
        if (bus.req != '0) begin
            check("grant_timeout", bus.req, 0);
            bus.req = '0;
        end
        repeat (3) tick();
    endtask

    // Both requesters hold read requests for six cycles regardless of grants.
    task automatic hold_tie_reads(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        int g;
        int w;
        bus.we    = 2'b00;
        bus.addr0 = a0;
        bus.addr1 = a1;
        g = cyc + 1;
        w = tie_winner();
        expect_access(w, 1'b0, (w != 0) ? a1 : a0, '0, g);
        w = tie_winner();
        expect_access(w, 1'b0, (w != 0) ? a1 : a0, '0, g + 3);
        bus.req = 2'b11;
        repeat (6) tick();
        bus.req = '0;
        repeat (3) tick();
    endtask

    task automatic reset_in_rdata();
        bus.we     = 2'b00;
        bus.addr0  = 2'b11;
        bus.wdata0 = 1'b1;
        expect_access(0, 1'b0, 2'b11, 1'b1, cyc + 1);
        bus.req = 2'b01;
        tick();
        bus.req = '0;
        tick();
        reset = 1'b1;
        tick();
        check_all_zero("rst_rdata");
        reset    = 1'b0;
        last_win = 1;
        repeat (3) tick();
        check_all_zero("post_rst");
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = DW'($urandom);
        bus.req    = '0;
        bus.we     = '0;
        bus.addr0  = '0;
        bus.addr1  = '0;
        bus.wdata0 = '0;
        bus.wdata1 = '0;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        #1;
        reset   = 1'b0;
        load_en = 1'b0;
        mon_en  = 1'b1;
        tick();

        run_round(2'b01, 2'b01, 2'b10, 2'b00, 1'b1, 1'b0);
        run_round(2'b10, 2'b10, 2'b00, 2'b11, 1'b0, 1'b1);
        run_round(2'b10, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0);
        run_round(2'b11, 2'b01, 2'b01, 2'b10, 1'b1, 1'b0);
        hold_tie_reads(2'b10, 2'b11);
        reset_in_rdata();
        hold_tie_reads(2'b01, 2'b11);

        for (int n = 0; n < 40; n++) begin
            run_round(2'($urandom_range(1, 3)), 2'($urandom), AW'($urandom), AW'($urandom),
                      DW'($urandom), DW'($urandom));
        end

        check("queue_drained", expq.size(), 0);
        check("read_drained", rd_pend, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 2, RAM address width in bits.
REQ-002 Parameter DATA_W, default 1, RAM data width in bits.
REQ-003 Port clock  input  1  single clock; all state updates on posedge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port req  input  2  per-requester access request, bit i = requester i.
REQ-006 Port we  input  2  per-requester write enable (1 write, 0 read).
REQ-007 Port addr0/addr1  input  ADDR_W  per-requester address.
REQ-008 Port wdata0/wdata1  input  DATA_W  per-requester write data.
REQ-009 Port gnt  output  2  one-hot grant pulse, one cycle, marks the RAM access cycle.
REQ-010 Port rvalid  output  2  one-hot read-data-valid pulse, one cycle.
REQ-011 Port rdata  output  DATA_W  read data, shared, valid only while rvalid != 0.
REQ-012 Port ram_en, ram_we  output  1 each  RAM access strobe and write enable.
REQ-013 Port ram_addr  output  ADDR_W; ram_wdata  output  DATA_W; ram_rdata  input  DATA_W (RAM read latency 1 cycle).

Function
REQ-014 FSM states IDLE, ACCESS, RDATA; exactly one active.
REQ-015 IDLE: when req != 0, latch winner index, its we, addr, wdata into registers; next state ACCESS. When req == 0, stay IDLE.
REQ-016 ACCESS: ram_en=1, ram_we/ram_addr/ram_wdata driven from latched values, gnt[winner]=1; next state RDATA if latched we=0, else IDLE.
REQ-017 RDATA: rvalid[winner]=1, rdata=ram_rdata; next state IDLE.
REQ-018 Outside ACCESS: ram_en=0, ram_we=0, gnt=0. Outside RDATA: rvalid=0, rdata=0.
REQ-019 Latency from req sampled in IDLE at edge t: gnt in cycle t+1; read rvalid in cycle t+2.
REQ-020 Throughput: write one per 2 cycles, read one per 3 cycles; no back-to-back ACCESS.
REQ-021 Requester holds req/we/addr/wdata stable until its gnt; deasserting req before gnt does not cancel an already-latched access.
REQ-022 Requests arriving in ACCESS or RDATA are ignored until the next IDLE cycle.
REQ-023 Tie (req=2'b11) resolved per REQ-027/REQ-028; the loser is served in the next IDLE if still requesting.
REQ-024 Address passed unmodified; no wrap or bounds logic (full ADDR_W space legal).

Reset
REQ-025 Reset while asserted: state IDLE, gnt=0, rvalid=0, rdata=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, latched registers 0, priority pointer initialised per REQ-027.
REQ-026 Reset in ACCESS or RDATA aborts the access: no rvalid issued, no further RAM strobe.

Configuration
REQ-027 Macro RAM_ARB_ROUND_ROBIN_EN defined: last-winner pointer, reset to 1; tie granted to requester other than last winner; pointer updates in each ACCESS cycle.
REQ-028 Macro undefined: fixed priority, requester 0 always wins ties; no pointer register exists.

Structure
REQ-029 Package ram_arb_pkg holds the state enum (IDLE, ACCESS, RDATA) and N_REQ=2 constant.
REQ-030 Sub-module ram_arb_pick: combinational winner select from req and pointer (pointer input ignored when macro undefined).

Verification
REQ-031 Single write: req=01, we=01, addr0=2'b10, wdata0=1 -> cycle+1 gnt=01, ram_en=1, ram_we=1, ram_addr=2'b10, ram_wdata=1; cycle+2 IDLE.
REQ-032 Single read: req=10, we=00, addr1=2'b11, RAM holds 1 -> gnt=10 at +1, rvalid=10 and rdata=1 at +2.
REQ-033 Tie, both reads, held 6 cycles: with RAM_ARB_ROUND_ROBIN_EN grants alternate 01,10; without, gnt=01 every ACCESS, requester 1 starved.
REQ-034 Reset asserted in RDATA -> next cycle rvalid=0, state IDLE, all outputs 0.
REQ-035 req dropped to 00 in ACCESS cycle -> access completes, gnt pulse still one cycle, no second grant.
